fixed_round_cast: RTL and testbench

- Pipelined, multi-channel fixed-point cast: rescales each signed lane from IN_FRAC_WIDTH to OUT_FRAC_WIDTH with a runtime-selectable rounding mode, then saturates or wraps to OUT_WIDTH.
- Sits between arithmetic stages in the cast library. Uses the standard valid/ready stream handshake, per-lane overflow flags, and a sticky overflow beat counter.

---
 rtl/cast_pkg.sv | 34 +++
 rtl/fixed_round_cast_chk.sv | 14 +
 rtl/fixed_round_lane.sv | 57 +++++
 rtl/fixed_round_cast.sv | 133 +++++++++++++
 tb/tb_fixed_round_cast.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cast_pkg.sv
// Shared definitions for the fixed-point cast library.
//   round_mode_t : per-beat rounding mode carried on data_in_mode
//   sat_clamp    : clamp a sign-extended value into a signed range of a
//                  given width (width must be 2..63)
package cast_pkg;

   typedef enum logic [1:0] {
      FLOOR     = 2'd0,
      TRUNC     = 2'd1,
      HALF_UP   = 2'd2,
      HALF_EVEN = 2'd3
   } round_mode_t;

   // Values are carried at 64 bits so one function serves any lane width.
   function automatic logic signed [63:0] sat_clamp(
      input logic signed [63:0] value,
      input int unsigned        width
   );
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      logic signed [63:0] res_v;
      max_v = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 32'd1));
      if (value > max_v) begin
         res_v = max_v;
      end else if (value < min_v) begin
         res_v = min_v;
      end else begin
         res_v = value;
      end
      return res_v;
   endfunction

endpackage

// File: rtl/fixed_round_cast_chk.sv
// Elaboration-time parameter legality check for fixed_round_cast.
// No ports; instantiated by the top so an illegal build fails to elaborate.
module fixed_round_cast_chk #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 4
) ();

   generate
      if ((IN_WIDTH < 2) || (OUT_WIDTH < 2)) begin : g_width_error
         $error("fixed_round_cast: IN_WIDTH and OUT_WIDTH must both be at least 2");
      end
   endgenerate

endmodule

// File: rtl/fixed_round_lane.sv
// One lane of the rounding step (purely combinational).
//   lane_in : signed input sample with IN_FRAC_WIDTH fractional bits
//   mode    : rounding mode (cast_pkg::round_mode_t encoding)
//   rounded : signed result with OUT_FRAC_WIDTH fractional bits, R_WIDTH wide
//             so the rounding increment can never overflow
module fixed_round_lane
   import cast_pkg::*;
#(
   parameter int IN_WIDTH       = 8,
   parameter int IN_FRAC_WIDTH  = 4,
   parameter int OUT_FRAC_WIDTH = 1,
   parameter int R_WIDTH        = 10
) (
   input  logic [IN_WIDTH-1:0] lane_in,
   input  logic [1:0]          mode,
   output logic [R_WIDTH-1:0]  rounded
);

   localparam int SHIFT = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;

   logic signed [R_WIDTH-1:0] ext_s;

   assign ext_s = R_WIDTH'($signed(lane_in));

   generate
      if (SHIFT > 0) begin : g_round
         localparam logic [SHIFT-1:0] HALF = SHIFT'(2 ** (SHIFT - 1));

         logic signed [R_WIDTH-1:0] q_s;
         logic [SHIFT-1:0]          rem_s;
         logic                      inc_s;

         // Arithmetic shift gives floor; the discarded bits are an
         // unsigned remainder in [0, 2^SHIFT).
         assign q_s   = ext_s >>> SHIFT;
         assign rem_s = ext_s[SHIFT-1:0];

         // Select the +1 correction applied on top of floor
         always_comb begin
            inc_s = 1'b0;
            case (round_mode_t'(mode))
               FLOOR:     inc_s = 1'b0;
               TRUNC:     inc_s = ext_s[R_WIDTH-1] && (rem_s != {SHIFT{1'b0}});
               HALF_UP:   inc_s = (rem_s >= HALF);
               HALF_EVEN: inc_s = (rem_s > HALF) || ((rem_s == HALF) && q_s[0]);
               default:   inc_s = 1'b0;
            endcase
         end

         assign rounded = q_s + {{(R_WIDTH-1){1'b0}}, inc_s};
      end else begin : g_exact
         // Gaining fractional bits is exact: just scale up.
         assign rounded = ext_s <<< (-SHIFT);
      end
   endgenerate

endmodule

// File: rtl/fixed_round_cast.sv
// Pipelined multi-lane fixed-point cast: round to OUT_FRAC_WIDTH with a
// per-beat mode, then saturate or wrap to OUT_WIDTH.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   data_in/_mode/_valid  input beat (lane 0 in LSBs), rounding mode, valid
//   data_in_ready         input ready (combinational from data_out_ready)
//   data_out/_ovf/_valid  registered result, per-lane overflow, valid
//   data_out_ready        output ready
//   ovf_count, ovf_clear  saturating count of delivered overflow beats, clear
module fixed_round_cast
   import cast_pkg::*;
#(
   parameter int IN_WIDTH       = 8,
   parameter int IN_FRAC_WIDTH  = 4,
   parameter int OUT_WIDTH      = 4,
   parameter int OUT_FRAC_WIDTH = 1,
   parameter int CHANNELS       = 4,
   parameter int SATURATE       = 1,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CHANNELS*IN_WIDTH-1:0]   data_in,
   input  logic [1:0]                     data_in_mode,
   input  logic                           data_in_valid,
   output logic                           data_in_ready,
   output logic [CHANNELS*OUT_WIDTH-1:0]  data_out,
   output logic [CHANNELS-1:0]            data_out_ovf,
   output logic                           data_out_valid,
   input  logic                           data_out_ready,
   output logic [CNT_WIDTH-1:0]           ovf_count,
   input  logic                           ovf_clear
);

   localparam int SHIFT   = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
   // Two guard bits absorb the rounding increment; extra bits cover
   // the left shift when the output has more fractional bits.
   localparam int R_WIDTH = IN_WIDTH + 2 + ((SHIFT < 0) ? -SHIFT : 0);

   logic                                 v1_r;
   logic                                 v2_r;
   logic                                 adv1_s;
   logic                                 adv2_s;
   logic [CHANNELS-1:0][R_WIDTH-1:0]     rounded_s;
   logic [CHANNELS-1:0][R_WIDTH-1:0]     r1_r;
   logic [CHANNELS-1:0][OUT_WIDTH-1:0]   cast_s;
   logic [CHANNELS-1:0][OUT_WIDTH-1:0]   out_r;
   logic [CHANNELS-1:0]                  ovf_s;
   logic [CHANNELS-1:0]                  ovf_r;
   logic [CNT_WIDTH-1:0]                 cnt_r;

   fixed_round_cast_chk #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_chk ();

   // A stage may load when it is empty or its contents move on this cycle.
   assign adv2_s        = !v2_r || data_out_ready;
   assign adv1_s        = !v1_r || adv2_s;
   assign data_in_ready = adv1_s;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
         logic signed [63:0] wide_s;
         logic signed [63:0] clamped_s;

         fixed_round_lane #(
            .IN_WIDTH       (IN_WIDTH),
            .IN_FRAC_WIDTH  (IN_FRAC_WIDTH),
            .OUT_FRAC_WIDTH (OUT_FRAC_WIDTH),
            .R_WIDTH        (R_WIDTH)
         ) u_lane (
            .lane_in (data_in[gi*IN_WIDTH +: IN_WIDTH]),
            .mode    (data_in_mode),
            .rounded (rounded_s[gi])
         );

         // Overflow is exactly "clamping would change the value", so the
         // flag is reported identically in saturate and wrap builds.
         assign wide_s      = 64'($signed(r1_r[gi]));
         assign clamped_s   = sat_clamp(wide_s, OUT_WIDTH);
         assign ovf_s[gi]   = (clamped_s != wide_s);
         assign cast_s[gi]  = (SATURATE != 0) ? clamped_s[OUT_WIDTH-1:0]
                                              : r1_r[gi][OUT_WIDTH-1:0];
      end
   endgenerate

   // Stage 1: capture the rounded lanes of an accepted beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_r <= 1'b0;
         r1_r <= {(CHANNELS*R_WIDTH){1'b0}};
      end else if (adv1_s) begin
         v1_r <= data_in_valid;
         if (data_in_valid) begin
            r1_r <= rounded_s;
         end
      end
   end

   // Stage 2: capture the cast result and overflow flags; holds while stalled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2_r  <= 1'b0;
         out_r <= {(CHANNELS*OUT_WIDTH){1'b0}};
         ovf_r <= {CHANNELS{1'b0}};
      end else if (adv2_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            out_r <= cast_s;
            ovf_r <= ovf_s;
         end
      end
   end

   // Overflow beat counter: clear wins, saturates at all-ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (ovf_clear) begin
         cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (v2_r && data_out_ready && (|ovf_r) &&
                   (cnt_r != {CNT_WIDTH{1'b1}})) begin
         cnt_r <= cnt_r + CNT_WIDTH'(1'b1);
      end
   end

   assign data_out       = out_r;
   assign data_out_ovf   = ovf_r;
   assign data_out_valid = v2_r;
   assign ovf_count      = cnt_r;

endmodule

// File: tb/tb_fixed_round_cast.sv
// Directed, table-driven bench for fixed_round_cast. A default build and a
// wrap build with a 2-bit counter see the same stimulus.
module tb_fixed_round_cast;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_in;
   logic [1:0]  data_in_mode;
   logic        data_in_valid;
   logic        data_in_ready;
   logic [15:0] data_out;
   logic [3:0]  data_out_ovf;
   logic        data_out_valid;
   logic        data_out_ready;
   logic [15:0] ovf_count;
   logic        ovf_clear;

   logic        in_ready_w;
   logic [15:0] out_w;
   logic [3:0]  ovf_w;
   logic        valid_w;
   logic [1:0]  count_w;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] din;
      logic [1:0]  mode;
      logic [15:0] exp_sat;
      logic [15:0] exp_wrap;
      logic [3:0]  exp_ovf;
   } vec_t;

   vec_t vecs [8];

   fixed_round_cast dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_in        (data_in),
      .data_in_mode   (data_in_mode),
      .data_in_valid  (data_in_valid),
      .data_in_ready  (data_in_ready),
      .data_out       (data_out),
      .data_out_ovf   (data_out_ovf),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .ovf_count      (ovf_count),
      .ovf_clear      (ovf_clear)
   );

   fixed_round_cast #(.SATURATE(0), .CNT_WIDTH(2)) dut_w (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_in        (data_in),
      .data_in_mode   (data_in_mode),
      .data_in_valid  (data_in_valid),
      .data_in_ready  (in_ready_w),
      .data_out       (out_w),
      .data_out_ovf   (ovf_w),
      .data_out_valid (valid_w),
      .data_out_ready (data_out_ready),
      .ovf_count      (count_w),
      .ovf_clear      (ovf_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Single beat with output always ready; optional clear on its handshake edge.
   task automatic send_one(input int idx, input logic clr);
      @(posedge clk); #1;
      data_in = vecs[idx].din; data_in_mode = vecs[idx].mode;
      data_in_valid = 1'b1; data_out_ready = 1'b1;
      @(posedge clk); #1;
      data_in_valid = 1'b0;
      @(posedge clk); #1;
      ovf_clear = clr;
      @(posedge clk); #1;
      ovf_clear = 1'b0;
   endtask

   // Stream nbeats through the default build; bp selects ready pattern 1,0,0,1.
   task automatic run_stream(input int nbeats, input logic bp);
      int q_idx[$];
      int q_cyc[$];
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic stalled = 1'b0;
      logic [15:0] held_out = 16'h0;
      logic [3:0]  held_ovf = 4'h0;
      logic [3:0]  pat = 4'b1001;
      while ((got < nbeats) && (cyc < 300)) begin
         @(posedge clk); #1;
         data_in_valid  = (sent < nbeats);
         data_in        = vecs[sent % 8].din;
         data_in_mode   = vecs[sent % 8].mode;
         data_out_ready = bp ? pat[cyc % 4] : 1'b1;
         @(negedge clk);
         check("in_ready", {63'd0, data_in_ready},
               {63'd0, !((q_idx.size() == 2) && !data_out_ready)});
         if (stalled) begin
            check("stall_valid", {63'd0, data_out_valid}, 64'd1);
            check("stall_hold", {44'd0, data_out_ovf, data_out}, {44'd0, held_ovf, held_out});
         end
         if (data_out_valid && data_out_ready) begin
            if (q_idx.size() == 0) begin
               check("extra_beat", 64'd1, 64'd0);
            end else begin
               int idx;
               int acc;
               idx = q_idx.pop_front();
               acc = q_cyc.pop_front();
               check("stream_out", {48'd0, data_out}, {48'd0, vecs[idx].exp_sat});
               check("stream_ovf", {60'd0, data_out_ovf}, {60'd0, vecs[idx].exp_ovf});
               if (!bp) begin
                  check("latency", 64'(cyc - acc), 64'd2);
               end
            end
            got++;
         end
         stalled  = data_out_valid && !data_out_ready;
         held_out = data_out;
         held_ovf = data_out_ovf;
         if (data_in_valid && data_in_ready) begin
            q_idx.push_back(sent % 8);
            q_cyc.push_back(cyc);
            sent++;
         end
         cyc++;
      end
      if (got < nbeats) begin
         checks++;
         errors++;
         $display("FAIL stream_timeout actual=%0d beats required=%0d beats", got, nbeats);
      end
      @(posedge clk); #1;
      data_in_valid = 1'b0; data_out_ready = 1'b1;
      @(negedge clk);
      check("no_extra", {63'd0, data_out_valid}, 64'd0);
   endtask

   initial begin
      //            din           mode  sat      wrap     ovf
      vecs[0] = '{32'hEC14D42C, 2'd0, 16'hD2A5, 16'hD2A5, 4'b0000};
      vecs[1] = '{32'hEC14D42C, 2'd1, 16'hE2B5, 16'hE2B5, 4'b0000};
      vecs[2] = '{32'hEC14D42C, 2'd2, 16'hE3B6, 16'hE3B6, 4'b0000};
      vecs[3] = '{32'hEC14D42C, 2'd3, 16'hE2A6, 16'hE2A6, 4'b0000};
      vecs[4] = '{32'hC038807F, 2'd0, 16'h8787, 16'h870F, 4'b0011};
      vecs[5] = '{32'hFDBF3C7F, 2'd2, 16'h0877, 16'h0880, 4'b0011};
      vecs[6] = '{32'h0003FDBF, 2'd1, 16'h0008, 16'h0008, 4'b0000};
      vecs[7] = '{32'h80BFFD3C, 2'd3, 16'h8807, 16'h0808, 4'b1001};

      rst_n = 1'b0; data_in = 32'h0; data_in_mode = 2'd0; data_in_valid = 1'b0;
      data_out_ready = 1'b1; ovf_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_valid", {63'd0, data_out_valid}, 64'd0);
      check("rst_out", {48'd0, data_out}, 64'd0);
      check("rst_ovf", {60'd0, data_out_ovf}, 64'd0);
      check("rst_count", {48'd0, ovf_count}, 64'd0);
      check("rst_in_ready", {63'd0, data_in_ready}, 64'd1);

      // Rounding table: one beat at a time, both builds.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         data_in = vecs[i].din; data_in_mode = vecs[i].mode; data_in_valid = 1'b1;
         @(posedge clk); #1;
         data_in_valid = 1'b0;
         @(posedge clk); #1;
         check("tab_valid", {63'd0, data_out_valid}, 64'd1);
         check("tab_sat", {48'd0, data_out}, {48'd0, vecs[i].exp_sat});
         check("tab_ovf", {60'd0, data_out_ovf}, {60'd0, vecs[i].exp_ovf});
         check("tab_wrap", {48'd0, out_w}, {48'd0, vecs[i].exp_wrap});
         check("tab_wrap_ovf", {60'd0, ovf_w}, {60'd0, vecs[i].exp_ovf});
      end
      @(posedge clk); #1;
      check("tab_count", {48'd0, ovf_count}, 64'd3);
      check("tab_count_w", {62'd0, count_w}, 64'd3);
      ovf_clear = 1'b1;
      @(posedge clk); #1;
      ovf_clear = 1'b0;
      check("clr_count", {48'd0, ovf_count}, 64'd0);
      check("clr_count_w", {62'd0, count_w}, 64'd0);

      // Counter: 1,2,3 then clear on the 4th handshake, then saturation of the 2-bit build.
      for (int i = 1; i <= 3; i++) begin
         send_one(4, 1'b0);
         check("cnt_inc", {48'd0, ovf_count}, 64'(i));
         check("cnt_inc_w", {62'd0, count_w}, 64'(i));
      end
      send_one(5, 1'b1);
      check("cnt_clr_prio", {48'd0, ovf_count}, 64'd0);
      check("cnt_clr_prio_w", {62'd0, count_w}, 64'd0);
      for (int i = 1; i <= 5; i++) begin
         send_one(7, 1'b0);
         check("cnt_run", {48'd0, ovf_count}, 64'(i));
         check("cnt_sat_w", {62'd0, count_w}, 64'((i > 3) ? 3 : i));
      end
      send_one(0, 1'b0);
      check("cnt_no_ovf", {48'd0, ovf_count}, 64'd5);

      // Throughput/latency, then backpressure.
      run_stream(6, 1'b0);
      run_stream(10, 1'b1);

      // Reset with both stages full.
      @(posedge clk); #1;
      data_out_ready = 1'b0; data_in_valid = 1'b1;
      data_in = vecs[0].din; data_in_mode = vecs[0].mode;
      @(posedge clk); #1;
      data_in = vecs[1].din; data_in_mode = vecs[1].mode;
      @(posedge clk); #1;
      data_in_valid = 1'b0;
      check("full_valid", {63'd0, data_out_valid}, 64'd1);
      check("full_in_ready", {63'd0, data_in_ready}, 64'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_valid", {63'd0, data_out_valid}, 64'd0);
      check("mid_rst_count", {48'd0, ovf_count}, 64'd0);
      check("mid_rst_out", {48'd0, data_out}, 64'd0);
      rst_n = 1'b1; data_out_ready = 1'b1;
      check("post_rst_ready", {63'd0, data_in_ready}, 64'd1);
      @(posedge clk); #1;
      check("no_stale1", {63'd0, data_out_valid}, 64'd0);
      @(posedge clk); #1;
      check("no_stale2", {63'd0, data_out_valid}, 64'd0);
      data_in = vecs[2].din; data_in_mode = vecs[2].mode; data_in_valid = 1'b1;
      @(posedge clk); #1;
      data_in_valid = 1'b0;
      @(posedge clk); #1;
      check("new_valid", {63'd0, data_out_valid}, 64'd1);
      check("new_out", {48'd0, data_out}, {48'd0, vecs[2].exp_sat});
      check("new_ovf", {60'd0, data_out_ovf}, 64'd0);
      @(posedge clk); #1;
      check("new_drained", {63'd0, data_out_valid}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
